imem_fetch_responder: RTL

- Responder side of the instruction-fetch interface: accepts a PC-addressed fetch request and returns the 32-bit instruction word.
- Sits between the program counter / fetch logic in the IF stage and a word-organised instruction memory.
- Wait-state counter models slow memory; address faults (misaligned, out of range) are reported per response.
- Side load port fills the memory at boot.

---
 rtl/imem_fetch_responder_pkg.sv | 27 ++
 rtl/imem_fetch_responder_array.sv | 26 ++
 rtl/imem_fetch_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared types for the instruction-fetch responder: fault codes, FSM states
// and the address fault classifier.
package fetch_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fsm_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Misalignment wins over range; the range test uses the full word address
  // so high addresses never alias onto the array.
  function automatic fault_e addr_fault(input logic [31:0] addr, input logic [31:0] depth);
    if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
    if ({2'b00, addr[31:2]} >= depth) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_fetch_responder_array.sv
// Word-organised instruction store: one synchronous write port, one registered
// read port. A same-edge read of a word being written returns the old word.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: accepts one PC-addressed request at a time, models memory
// wait states, and returns the instruction word or a fault code.
module imem_fetch_responder
  import fetch_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] FAULT_INSTR = NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [1:0]                     rsp_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic                           busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  fsm_state_e    state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  fault_e        fault_q;
  logic          use_mem;
  logic [31:0]   rd_data;
  fault_e        req_fault;
  logic          accept;
  logic          rd_en;
  logic [AW-1:0] rd_idx;

  assign req_fault = addr_fault(req_addr, 32'(DEPTH_WORDS));
  assign accept    = req_valid && req_ready;

  // The read fires on the edge that enters RESP; with no wait states that is
  // the accept edge itself, so the index comes straight from the request.
  assign rd_en  = (accept && req_fault == FAULT_NONE && WAIT_CYCLES == 0) ||
                  (state == WAIT && cnt == 4'd1);
  assign rd_idx = (state == IDLE) ? req_addr[AW+1:2] : idx_q;

  // Faulted responses never touch memory; the mux selects the fault word.
  assign rsp_instr = use_mem ? rd_data : FAULT_INSTR;
  assign rsp_fault = fault_q;

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      fault_q   <= FAULT_NONE;
      use_mem   <= 1'b0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q     <= req_addr[AW+1:2];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_fault != FAULT_NONE) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              fault_q   <= req_fault;
              use_mem   <= 1'b0;
            end else if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              fault_q   <= FAULT_NONE;
              use_mem   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            fault_q   <= FAULT_NONE;
            use_mem   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
